taxi_fare_engine: RTL and testbench
===================================

// Module: taxi_fare_engine
// PURPOSE
//  Parametrised successor to the taximeter fare calculator. Accumulates a trip fare in
//  packed BCD on a single clock, with these features:
//  - selectable tariff (normal/premium), each with its own base fare and step
//  - latched night surcharge
//  - free-distance allowance
//  - end-of-trip freeze
//  - saturation with a sticky overflow flag
//  The meter pulse is resynchronised internally. Sits between the odometer pulse source
//  and the 7-segment display driver.
// PARAMETERS
//  DIGITS       6         number of BCD digits in fare (>=3)
//  UNIT_DIGIT   2         digit index where the step is added (2 = hundreds)
//  BASE_NORMAL  24'h002800  BCD base fare, normal tariff, width 4*DIGITS
//  BASE_PREMIUM 24'h003000  BCD base fare, premium tariff
//  STEP_NORMAL  1         BCD step per pulse, normal (0-9)
//  STEP_PREMIUM 3         BCD step per pulse, premium (0-9)
//  NIGHT_EXTRA  1         extra step per pulse when night is latched (0-9)
//  FREE_PULSES  2         meter pulses covered by the base fare (0 = none)
// PORTS
//  clk       in   1          system clock
//  reset     in   1          synchronous, active-high
//  normal    in   1          start trip, normal tariff (level, sampled each clk)
//  premium   in   1          start trip, premium tariff
//  night     in   1          night surcharge request, latched at trip start
//  stop      in   1          end trip; freeze fare
//  meter     in   1          asynchronous odometer pulse, >=3 clk high and >=3 clk low
//  fare      out  4*DIGITS   packed BCD fare; digit i at [4i+3:4i]
//  state     out  2          current FSM state (encoding from taxi_pkg)
//  overflow  out  1          sticky; fare saturated at all-9s
// BEHAVIOUR
//  Reset and reset values
//  - reset is synchronous, active-high.
//  - reset values: fare=0, state=IDLE, overflow=0, free counter=0, night latch=0,
//    sync regs=0.
//  Meter path
//  - meter is sampled by a 2-FF synchroniser plus a delay FF.
//  - pulse = sync2 & ~sync3.
//  - if meter is first sampled high at edge N, fare updates at edge N+2.
//  - one increment per rising meter edge.
//  FSM: IDLE, FREE, RUN, HOLD
//  - Per-cycle priority: reset > normal > premium > stop > pulse.
//  - normal|premium in any state:
//    - fare = tariff base, overflow=0, night latch=night, free cnt=0
//    - state = FREE if FREE_PULSES>0, else RUN
//    - a pulse in the same cycle is dropped
//    - normal wins if both are high
//  - FREE: each pulse increments free cnt, fare unchanged. On pulse with
//    cnt==FREE_PULSES-1 -> RUN.
//  - RUN: each pulse adds addend = step(tariff) + (night latch ? NIGHT_EXTRA : 0).
//    - addend is a 2-digit BCD value, 0..18.
//    - it is added at digit UNIT_DIGIT; digits below UNIT_DIGIT are never touched.
//    - the carry ripples through all higher digits in the same cycle.
//  - stop in FREE/RUN -> HOLD. Fare is frozen; pulses are ignored.
//  - stop in IDLE/HOLD: no effect.
//  - pulses in IDLE: ignored. fare stays 0.
//  Arithmetic and saturation
//  - If the add carries out of the top digit: fare = all 9s, overflow=1.
//  - overflow then stays set until the next start or reset.
//  - Further pulses keep fare at all 9s.
//  - tariff and night are fixed for the whole trip. A mid-trip change of the night input
//    has no effect.
//  - reset mid-trip: takes effect at the next edge, discarding any pending pulse.
// STRUCTURE
//  - taxi_pkg holds:
//    - state_t enum: IDLE=0, FREE=1, RUN=2, HOLD=3
//    - tariff_t enum: NORMAL, PREMIUM
//    - bcd_t (logic [3:0])
//    - function to_bcd2(int) -> 8-bit BCD
//  - Sub-module bcd_step_adder:
//    - parametrised on DIGITS and UNIT_DIGIT
//    - combinational: fare_in, addend[7:0] BCD -> fare_out, carry_out
//  - Top level holds the synchroniser, FSM, free counter, night latch and saturation
//    logic.
// TESTING
//  1. Reset, then normal=1 for 1 clk, then 2 meter pulses (free), then 3 pulses
//     -> fare=24'h003100, state=RUN.
//  2. premium with night=1 latched, night dropped mid-trip, 2 free pulses + 4 pulses
//     -> fare=24'h004600 (+4 each).
//  3. Carry ripple: premium, pulses until fare passes 24'h009900 -> next pulse yields
//     24'h010200. Lower digits stay 0.
//  4. stop in RUN at fare 24'h003500, then 5 pulses -> fare stays 24'h003500,
//     state=HOLD. Then normal -> fare=24'h002800.
//  5. Saturation: DIGITS=3, base 12'h990 -> next pulse gives 12'h999, overflow=1.
//     Further pulses hold. reset clears both.
//  6. Simultaneous events:
//     - normal and pulse in same cycle -> base fare only
//     - normal+premium -> normal base
//     - reset+normal -> IDLE, fare=0
//     - meter pulse latency measured as exactly 2 edges

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types and helpers for the taximeter fare engine.
package taxi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FREE = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  typedef enum logic {NORMAL = 1'b0, PREMIUM = 1'b1} tariff_t;
  typedef logic [3:0] bcd_t;

  // Two-digit BCD encoding of 0..99.
  function automatic logic [7:0] to_bcd2(input int v);
    return {bcd_t'(v / 10), bcd_t'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_step_adder.sv
// Adds a 2-digit BCD addend into a packed BCD fare starting at UNIT_DIGIT.
module bcd_step_adder
  import taxi_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int UNIT_DIGIT = 2
) (
  input  logic [4*DIGITS-1:0] fare_in,
  input  logic [7:0]          addend,
  output logic [4*DIGITS-1:0] fare_out,
  output logic                carry_out
);

  logic       carry;
  logic [4:0] sum;
  bcd_t       add_d;

  always_comb begin
    fare_out = fare_in;
    carry    = 1'b0;
    sum      = 5'd0;
    add_d    = 4'd0;
    for (int i = UNIT_DIGIT; i < DIGITS; i++) begin
      add_d = (i == UNIT_DIGIT)     ? addend[3:0] :
              (i == UNIT_DIGIT + 1) ? addend[7:4] : 4'd0;
      sum   = {1'b0, fare_in[4*i +: 4]} + {1'b0, add_d} + {4'd0, carry};
      if (sum > 5'd9) begin
        sum   = sum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      fare_out[4*i +: 4] = sum[3:0];
    end
    // When the tens digit of the addend lands above the top digit it is itself an overflow.
    carry_out = carry | ((UNIT_DIGIT + 1 >= DIGITS) && (addend[7:4] != 4'd0));
  end

endmodule

// File: rtl/taxi_fare_engine.sv
// Taximeter fare engine: meter resync, trip FSM, free allowance, BCD accumulate, saturation.
module taxi_fare_engine
  import taxi_pkg::*;
#(
  parameter int                DIGITS       = 6,
  parameter int                UNIT_DIGIT   = 2,
  parameter logic [4*DIGITS-1:0] BASE_NORMAL  = 24'h002800,
  parameter logic [4*DIGITS-1:0] BASE_PREMIUM = 24'h003000,
  parameter int                STEP_NORMAL  = 1,
  parameter int                STEP_PREMIUM = 3,
  parameter int                NIGHT_EXTRA  = 1,
  parameter int                FREE_PULSES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                normal,
  input  logic                premium,
  input  logic                night,
  input  logic                stop,
  input  logic                meter,
  output logic [4*DIGITS-1:0] fare,
  output logic [1:0]          state,
  output logic                overflow
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_FREE = 2'(FREE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_HOLD = 2'(HOLD);
  localparam int         FCW    = (FREE_PULSES > 1) ? $clog2(FREE_PULSES) : 1;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic                sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] fare_q, fare_d;
  logic                ovf_q, ovf_d;
  logic [FCW-1:0]      free_cnt_q, free_cnt_d;
  logic                night_q, night_d;
  tariff_t             tariff_q, tariff_d;

  logic                pulse;
  int                  addend_int;
  logic [7:0]          addend;
  logic [4*DIGITS-1:0] sum_fare;
  logic                sum_carry;

  bcd_step_adder #(.DIGITS(DIGITS), .UNIT_DIGIT(UNIT_DIGIT)) u_add (
    .fare_in  (fare_q),
    .addend   (addend),
    .fare_out (sum_fare),
    .carry_out(sum_carry)
  );

  always_comb begin
    sync1_d    = meter;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    state_d    = state_q;
    fare_d     = fare_q;
    ovf_d      = ovf_q;
    free_cnt_d = free_cnt_q;
    night_d    = night_q;
    tariff_d   = tariff_q;

    pulse      = sync2_q & ~sync3_q;
    addend_int = ((tariff_q == PREMIUM) ? STEP_PREMIUM : STEP_NORMAL) +
                 (night_q ? NIGHT_EXTRA : 0);
    addend     = to_bcd2(addend_int);

    // A trip start swallows any pulse arriving in the same cycle.
    if (normal || premium) begin
      tariff_d   = normal ? NORMAL : PREMIUM;
      fare_d     = normal ? BASE_NORMAL : BASE_PREMIUM;
      ovf_d      = 1'b0;
      night_d    = night;
      free_cnt_d = '0;
      state_d    = (FREE_PULSES > 0) ? S_FREE : S_RUN;
    end else if (stop && (state_q == S_FREE || state_q == S_RUN)) begin
      state_d = S_HOLD;
    end else if (pulse) begin
      case (state_q)
        S_FREE: begin
          free_cnt_d = free_cnt_q + FCW'(1);
          if (free_cnt_q == FCW'(FREE_PULSES - 1)) state_d = S_RUN;
        end
        S_RUN: begin
          if (sum_carry || ovf_q) begin
            fare_d = ALL_NINES;
            ovf_d  = 1'b1;
          end else begin
            fare_d = sum_fare;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= S_IDLE;
      fare_q     <= '0;
      ovf_q      <= 1'b0;
      free_cnt_q <= '0;
      night_q    <= 1'b0;
      tariff_q   <= NORMAL;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      state_q    <= state_d;
      fare_q     <= fare_d;
      ovf_q      <= ovf_d;
      free_cnt_q <= free_cnt_d;
      night_q    <= night_d;
      tariff_q   <= tariff_d;
    end
  end

  assign fare     = fare_q;
  assign state    = state_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_taxi_fare_engine.sv
// Directed scoreboard bench for taxi_fare_engine (default build plus a 3-digit saturating build).
module tb_taxi_fare_engine;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_FREE = 2'd1, ST_RUN = 2'd2, ST_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, normal = 1'b0, premium = 1'b0, night = 1'b0, stop = 1'b0, meter = 1'b0;
  logic [23:0] fare;
  logic [1:0]  state;
  logic        overflow;
  logic [11:0] fare2;
  logic [1:0]  state2;
  logic        ovf2;

  always #5 clk = ~clk;

  taxi_fare_engine dut (
    .clk(clk), .reset(reset), .normal(normal), .premium(premium), .night(night),
    .stop(stop), .meter(meter), .fare(fare), .state(state), .overflow(overflow)
  );

  taxi_fare_engine #(
    .DIGITS(3), .UNIT_DIGIT(1), .BASE_NORMAL(12'h990), .BASE_PREMIUM(12'h500), .FREE_PULSES(0)
  ) dut2 (
    .clk(clk), .reset(reset), .normal(normal), .premium(premium), .night(night),
    .stop(stop), .meter(meter), .fare(fare2), .state(state2), .overflow(ovf2)
  );

  typedef struct {
    string       tag;
    bit          d2;
    logic [23:0] f;
    logic [1:0]  s;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   val;

  function automatic logic [23:0] int2bcd(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    meter = 1'b1; tick(3);
    meter = 1'b0; tick(3);
  endtask

  task automatic start(input bit n, input bit p, input bit nt);
    normal = n; premium = p; night = nt;
    tick(1);
    normal = 1'b0; premium = 1'b0;
  endtask

  task automatic exp(input string tag, input bit d2, input logic [23:0] f,
                     input logic [1:0] s, input logic o);
    exp_t e;
    e.tag = tag; e.d2 = d2; e.f = f; e.s = s; e.o = o;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [23:0] af;
    logic [1:0]  as;
    logic        ao;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      af = e.d2 ? {12'h000, fare2} : fare;
      as = e.d2 ? state2 : state;
      ao = e.d2 ? ovf2 : overflow;
      n_assert++;
      assert (af === e.f) else begin
        n_fail++; $error("FAIL %s fare: got %h expected %h", e.tag, af, e.f);
      end
      n_assert++;
      assert (as === e.s) else begin
        n_fail++; $error("FAIL %s state: got %0d expected %0d", e.tag, as, e.s);
      end
      n_assert++;
      assert (ao === e.o) else begin
        n_fail++; $error("FAIL %s overflow: got %b expected %b", e.tag, ao, e.o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle pulses
    exp("reset", 0, 24'h0, ST_IDLE, 1'b0);
    tick(3); reset = 1'b0; tick(1);
    chk();
    exp("idle_pulse", 0, 24'h0, ST_IDLE, 1'b0);
    pulse(); chk();

    // 1: normal trip, 2 free pulses, 3 paid pulses
    exp("t1_start", 0, 24'h002800, ST_FREE, 1'b0);
    start(1, 0, 0); chk();
    pulse();
    exp("t1_free", 0, 24'h002800, ST_RUN, 1'b0);
    pulse(); chk();
    val = 2800;
    for (int k = 0; k < 3; k++) begin
      val += 100;
      exp("t1_run", 0, int2bcd(val), ST_RUN, 1'b0);
      pulse(); chk();
    end

    // 2: premium with night latched, night dropped mid-trip
    exp("t2_start", 0, 24'h003000, ST_FREE, 1'b0);
    start(0, 1, 1); night = 1'b0; chk();
    pulse(); pulse();
    val = 3000;
    for (int k = 0; k < 4; k++) begin
      val += 400;
      exp("t2_run", 0, int2bcd(val), ST_RUN, 1'b0);
      pulse(); chk();
    end

    // 3: carry ripple past 9900
    start(0, 1, 0); pulse(); pulse();
    val = 3000;
    for (int k = 0; k < 24; k++) begin
      val += 300;
      exp("t3_ripple", 0, int2bcd(val), ST_RUN, 1'b0);
      pulse(); chk();
    end
    n_assert++;
    assert (fare[7:0] === 8'h00) else begin
      n_fail++; $error("FAIL t3_low_digits: got %h expected 00", fare[7:0]);
    end

    // 4: stop freezes, restart reloads base
    start(1, 0, 0); pulse(); pulse();
    for (int k = 0; k < 7; k++) pulse();
    exp("t4_stop", 0, 24'h003500, ST_HOLD, 1'b0);
    stop = 1'b1; tick(1); stop = 1'b0; chk();
    exp("t4_hold", 0, 24'h003500, ST_HOLD, 1'b0);
    for (int k = 0; k < 5; k++) pulse();
    chk();
    exp("t4_restart", 0, 24'h002800, ST_FREE, 1'b0);
    start(1, 0, 0); chk();

    // 5: saturation on the 3-digit build
    exp("t5_base", 1, 24'h000990, ST_RUN, 1'b0);
    start(1, 0, 0); chk();
    exp("t5_sat", 1, 24'h000999, ST_RUN, 1'b1);
    pulse(); chk();
    exp("t5_hold", 1, 24'h000999, ST_RUN, 1'b1);
    pulse(); chk();
    exp("t5_restart", 1, 24'h000990, ST_RUN, 1'b0);
    start(1, 0, 0); chk();
    pulse();
    exp("t5_reset", 1, 24'h000000, ST_IDLE, 1'b0);
    reset = 1'b1; tick(1); reset = 1'b0; chk();

    // 6a: start and pulse in the same cycle -> pulse dropped
    start(1, 0, 0); pulse(); pulse(); pulse();
    meter = 1'b1; tick(2);
    exp("t6_start_pulse", 0, 24'h002800, ST_FREE, 1'b0);
    normal = 1'b1; tick(1); normal = 1'b0;
    chk();
    tick(1); meter = 1'b0; tick(3);
    pulse();
    exp("t6_free_intact", 0, 24'h002800, ST_RUN, 1'b0);
    pulse(); chk();

    // 6b: normal wins over premium
    exp("t6_both", 0, 24'h002800, ST_FREE, 1'b0);
    start(1, 1, 0); chk();
    pulse(); pulse();
    exp("t6_both_step", 0, 24'h002900, ST_RUN, 1'b0);
    pulse(); chk();

    // 6c: reset beats normal
    exp("t6_reset_normal", 0, 24'h0, ST_IDLE, 1'b0);
    reset = 1'b1; normal = 1'b1; tick(1); reset = 1'b0; normal = 1'b0;
    chk();

    // 6d: meter-to-fare latency is exactly two edges
    start(1, 0, 0); pulse(); pulse();
    meter = 1'b1;
    exp("t6_lat_n", 0, 24'h002800, ST_RUN, 1'b0);
    tick(1); chk();
    exp("t6_lat_n1", 0, 24'h002800, ST_RUN, 1'b0);
    tick(1); chk();
    exp("t6_lat_n2", 0, 24'h002900, ST_RUN, 1'b0);
    tick(1); chk();
    meter = 1'b0; tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
